ili9341_spi_rx: RTL and testbench
=================================

// Module: ili9341_spi_rx
// PURPOSE
//  Receiving end of the ILI9341 4-wire SPI link (sck/mosi/cs/dc) driven by the display driver.
//  - Deserialises bytes and decodes CASET/PASET/RAMWR.
//  - Emits one (x,y,rgb565) pixel event per received pixel.
//  - Serves as the bench-side display model and as an on-chip link checker.
// PARAMETERS
//  SYNC_STAGES  2    flip-flop stages on each SPI input (>=2)
//  MAX_X        240  panel width; reset column window is 0..MAX_X-1
//  MAX_Y        320  panel height; reset page window is 0..MAX_Y-1
// PORTS
//  clk          in   1   system clock; must be >= 4x spi_sck frequency
//  rst          in   1   asynchronous, active-low reset
//  spi_sck      in   1   SPI clock, mode 0 (idle low), sampled on rising edge
//  spi_mosi     in   1   serial data, MSB first
//  spi_cs       in   1   chip select, active low
//  spi_dc       in   1   0 = command byte, 1 = data/parameter byte
//  byte_valid   out  1   one-cycle pulse: a byte has been received
//  byte_data    out  8   received byte; held until the next byte_valid
//  byte_is_data out  1   dc level captured on the byte's 8th sck edge
//  cur_cmd      out  8   last command opcode received
//  pix_valid    out  1   one-cycle pulse: a pixel has been written
//  pix_x        out  16  column of the pixel
//  pix_y        out  16  page (row) of the pixel
//  pix_rgb      out  16  RGB565 pixel value, first byte in [15:8]
//  frame_err    out  1   sticky; set when cs rises mid-byte; cleared by the next command byte
// BEHAVIOUR
//  Reset values: all outputs 0 except cur_cmd=8'h00; internal window x 0..MAX_X-1, y 0..MAX_Y-1.
//  Input capture and byte assembly:
//   - sck, mosi, cs and dc pass through SYNC_STAGES flip-flops.
//   - Rising sck is detected on the synchronised signal while cs is low; mosi is shifted in MSB first.
//   - byte_valid fires exactly SYNC_STAGES+1 clk cycles after the 8th sck edge at the pins.
//  cs behaviour:
//   - cs high clears the bit counter.
//   - cs rising with 1..7 bits pending discards the partial byte and sets frame_err.
//  Command decode:
//   - A command byte sets cur_cmd and resets the parameter index to 0.
//   - A command byte also ends any RAMWR stream and drops any half-received pixel.
//  Parameter FSM, states IDLE, CASET, PASET, RAMWR_HI, RAMWR_LO:
//   - CASET(2Ah): 4 data bytes, {xs_hi,xs_lo,xe_hi,xe_lo}. The window updates only after byte 4.
//     Bytes beyond the 4th are ignored.
//   - PASET(2Bh): same layout; updates ys/ye.
//   - RAMWR(2Ch): loads x=xs, y=ys, then alternates RAMWR_HI/RAMWR_LO per data byte.
//     In RAMWR_LO, pix_valid fires one cycle after that byte's byte_valid.
//   - Other opcodes go to IDLE; their data bytes appear only on the byte outputs.
//  Pixel address after each pixel:
//   - if x==xe: x=xs and y advances; if y==ye: y=ys (full-window wrap).
//   - else x=x+1.
//   - If xs>xe, the column window is treated as xs..xs (x stays at xs); same rule for y.
//  Timing and reset:
//   - cs going high does not change the FSM state; RAMWR resumes in the next transaction.
//   - Reset mid-byte or mid-pixel drops all partial state; no pulses are emitted.
//   - Arithmetic is 16-bit unsigned; there is no clamping to MAX_X/MAX_Y beyond the reset window.
// CONFIGURATION
//  ILI_RX_STATS_EN
//   - Defined: adds outputs cmd_count[15:0] and pix_count[31:0].
//     They increment on each command byte / pix_valid, wrap at all-ones, and reset to 0.
//   - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package ili9341_pkg: opcodes CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C,
//   CMD_SWRESET=8'h01, the FSM state encoding, and RGB565 width constants.
//  Sub-module spi_byte_rx: synchronisers, edge detect, shift register and bit counter.
//   Outputs byte_valid, byte_data, byte_is_data and the mid-byte abort flag.
//  Top level holds the command/parameter FSM and the pixel address counters.
// TESTING
//  1 Send cmd 2Ah with dc=0 -> byte_valid with byte_data=2Ah, byte_is_data=0, cur_cmd=2Ah,
//    latency SYNC_STAGES+1.
//  2 CASET 00,0A,00,0C; PASET 00,05,00,06; RAMWR F8,00 x6 ->
//    pixels (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), then (10,5) again; all rgb F800.
//  3 RAMWR with no prior window, 2 pixels 07E0/001F -> (0,0)=07E0, (1,0)=001F.
//  4 Raise cs after 5 bits of a byte -> no byte_valid, frame_err=1.
//    Next command byte clears frame_err.
//  5 RAMWR, one data byte, then cmd 00h -> no pix_valid.
//    A new RAMWR restarts at (xs,ys).
//  6 Assert reset mid-RAMWR -> outputs 0, window 0..239 x 0..319.
//    With ILI_RX_STATS_EN: counters 0.

Source files
------------

// File: rtl/ili9341_spi_rx_pkg.sv
// ili9341_pkg: shared definitions for the ILI9341 SPI receiver.
//   - Command opcodes decoded by the receiver.
//   - Parameter FSM state encoding.
//   - RGB565 field widths.
//   - A helper that resolves inverted window bounds.
// The optional statistics counters are enabled with the macro ILI_RX_STATS_EN.
package ili9341_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int RGB565_R_W = 5;
    localparam int RGB565_G_W = 6;
    localparam int RGB565_B_W = 5;
    localparam int RGB565_W   = RGB565_R_W + RGB565_G_W + RGB565_B_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } rx_state_t;

    // A window whose start lies beyond its end collapses to the single start
    // coordinate, so the effective end is the larger of the two.
    function automatic logic [15:0] window_end(input logic [15:0] first,
                                               input logic [15:0] last);
        return (first > last) ? first : last;
    endfunction

endpackage

// File: rtl/ili9341_spi_rx_if.sv
// ili9341_spi_rx_if: bundles the 4-wire SPI pins and the decoded outputs
// of the ILI9341 receiver.
//   master modport : drives spi_sck/spi_mosi/spi_cs/spi_dc, observes results
//   slave modport  : the receiver (consumes SPI pins, drives byte/pixel outputs)
// With ILI_RX_STATS_EN defined, cmd_count[15:0] and pix_count[31:0] are added.
interface ili9341_spi_rx_if;
    import ili9341_pkg::*;

    logic                spi_sck;
    logic                spi_mosi;
    logic                spi_cs;
    logic                spi_dc;

    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                byte_is_data;
    logic [7:0]          cur_cmd;
    logic                pix_valid;
    logic [15:0]         pix_x;
    logic [15:0]         pix_y;
    logic [RGB565_W-1:0] pix_rgb;
    logic                frame_err;
`ifdef ILI_RX_STATS_EN
    logic [15:0]         cmd_count;
    logic [31:0]         pix_count;
`endif

    modport master (
        output spi_sck, output spi_mosi, output spi_cs, output spi_dc,
        input  byte_valid, input byte_data, input byte_is_data, input cur_cmd,
        input  pix_valid, input pix_x, input pix_y, input pix_rgb, input frame_err
`ifdef ILI_RX_STATS_EN
        , input cmd_count, input pix_count
`endif
    );

    modport slave (
        input  spi_sck, input spi_mosi, input spi_cs, input spi_dc,
        output byte_valid, output byte_data, output byte_is_data, output cur_cmd,
        output pix_valid, output pix_x, output pix_y, output pix_rgb, output frame_err
`ifdef ILI_RX_STATS_EN
        , output cmd_count, output pix_count
`endif
    );

endinterface

// File: rtl/ili9341_spi_rx_byte.sv
// spi_byte_rx: synchronises the SPI pins into the clk domain and assembles
// MSB-first bytes on rising sck while cs is low.
//   clk, rst      system clock, asynchronous active-low reset
//   sck/mosi/cs/dc raw SPI pins
//   byte_valid    one-cycle pulse, SYNC_STAGES+1 clks after the 8th sck edge
//   byte_data     assembled byte, held until the next byte_valid
//   byte_is_data  dc level sampled with the 8th bit
//   abort         one-cycle pulse when cs rises with a partial byte pending
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       abort
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] dc_sync;

    logic       sck_s, mosi_s, cs_s, dc_s;
    logic       sck_prev;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;

    // All four pins go through identical chains so mosi/dc/cs stay aligned
    // with the sck edge that samples them. cs resets to its inactive level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            dc_sync   <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];

    // cs high holds the bit counter at zero; a non-zero count seen while cs
    // is high means the byte was cut short, which is flagged exactly once
    // because the counter is cleared in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_prev     <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            abort        <= 1'b0;
        end else begin
            sck_prev   <= sck_s;
            byte_valid <= 1'b0;
            abort      <= 1'b0;
            if (cs_s) begin
                bit_cnt <= '0;
                if (bit_cnt != 3'd0) begin
                    abort <= 1'b1;
                end
            end else if (sck_s && !sck_prev) begin
                shift_reg <= {shift_reg[5:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= {shift_reg, mosi_s};
                    byte_is_data <= dc_s;
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_spi_rx.sv
// ili9341_spi_rx: receiving end of the ILI9341 4-wire SPI link.
// Decodes CASET/PASET/RAMWR and emits one (x, y, rgb565) event per pixel.
//   clk   system clock, at least 4x the sck frequency
//   rst   asynchronous active-low reset
//   bus   ili9341_spi_rx_if.slave: SPI pins in; byte_valid/byte_data/
//         byte_is_data/cur_cmd/pix_valid/pix_x/pix_y/pix_rgb/frame_err out
// Parameters: SYNC_STAGES (>=2) input synchroniser depth, MAX_X/MAX_Y panel
// size used for the reset address window.
// Optional macro ILI_RX_STATS_EN adds bus.cmd_count and bus.pix_count.
module ili9341_spi_rx
    import ili9341_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_X       = 240,
    parameter int MAX_Y       = 320
) (
    input  logic                  clk,
    input  logic                  rst,
    ili9341_spi_rx_if.slave       bus
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_is_data;
    logic       rx_abort;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk          (clk),
        .rst          (rst),
        .sck          (bus.spi_sck),
        .mosi         (bus.spi_mosi),
        .cs           (bus.spi_cs),
        .dc           (bus.spi_dc),
        .byte_valid   (rx_valid),
        .byte_data    (rx_data),
        .byte_is_data (rx_is_data),
        .abort        (rx_abort)
    );

    rx_state_t           state;
    logic [2:0]          param_idx;
    logic [7:0]          param_b0, param_b1, param_b2;
    logic [15:0]         xs, xe, ys, ye;
    logic [15:0]         x, y;
    logic [7:0]          pix_hi;
    logic [7:0]          cur_cmd;
    logic                frame_err;
    logic                pix_valid;
    logic [15:0]         pix_x, pix_y;
    logic [RGB565_W-1:0] pix_rgb;

    // Command/parameter FSM plus address counters. A command byte always
    // restarts parameter collection and abandons any half pixel, since
    // pix_hi is only consumed from RAMWR_LO. cs does not touch the state,
    // so a RAMWR stream continues across transactions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            param_idx <= '0;
            param_b0  <= '0;
            param_b1  <= '0;
            param_b2  <= '0;
            xs        <= '0;
            xe        <= 16'(MAX_X - 1);
            ys        <= '0;
            ye        <= 16'(MAX_Y - 1);
            x         <= '0;
            y         <= '0;
            pix_hi    <= '0;
            cur_cmd   <= 8'h00;
            frame_err <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (rx_valid && !rx_is_data) begin
                cur_cmd   <= rx_data;
                param_idx <= '0;
                frame_err <= 1'b0;
                case (rx_data)
                    CMD_CASET: state <= ST_CASET;
                    CMD_PASET: state <= ST_PASET;
                    CMD_RAMWR: begin
                        state <= ST_RAMWR_HI;
                        x     <= xs;
                        y     <= ys;
                    end
                    default:   state <= ST_IDLE;
                endcase
            end else if (rx_valid) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        // Index saturates at 4 so trailing bytes are ignored.
                        if (param_idx != 3'd4) begin
                            param_idx <= param_idx + 3'd1;
                        end
                        case (param_idx)
                            3'd0: param_b0 <= rx_data;
                            3'd1: param_b1 <= rx_data;
                            3'd2: param_b2 <= rx_data;
                            3'd3: begin
                                if (state == ST_CASET) begin
                                    xs <= {param_b0, param_b1};
                                    xe <= {param_b2, rx_data};
                                end else begin
                                    ys <= {param_b0, param_b1};
                                    ye <= {param_b2, rx_data};
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_RAMWR_HI: begin
                        pix_hi <= rx_data;
                        state  <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        pix_valid <= 1'b1;
                        pix_x     <= x;
                        pix_y     <= y;
                        pix_rgb   <= {pix_hi, rx_data};
                        state     <= ST_RAMWR_HI;
                        if (x == window_end(xs, xe)) begin
                            x <= xs;
                            if (y == window_end(ys, ye)) begin
                                y <= ys;
                            end else begin
                                y <= y + 16'd1;
                            end
                        end else begin
                            x <= x + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (rx_abort) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef ILI_RX_STATS_EN
    logic [15:0] cmd_count;
    logic [31:0] pix_count;

    // Free-running counters that wrap naturally at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_count <= '0;
            pix_count <= '0;
        end else begin
            if (rx_valid && !rx_is_data) begin
                cmd_count <= cmd_count + 16'd1;
            end
            if (rx_valid && rx_is_data && state == ST_RAMWR_LO) begin
                pix_count <= pix_count + 32'd1;
            end
        end
    end

    assign bus.cmd_count = cmd_count;
    assign bus.pix_count = pix_count;
`endif

    assign bus.byte_valid   = rx_valid;
    assign bus.byte_data    = rx_data;
    assign bus.byte_is_data = rx_is_data;
    assign bus.cur_cmd      = cur_cmd;
    assign bus.pix_valid    = pix_valid;
    assign bus.pix_x        = pix_x;
    assign bus.pix_y        = pix_y;
    assign bus.pix_rgb      = pix_rgb;
    assign bus.frame_err    = frame_err;

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// tb_ili9341_spi_rx: directed self-checking bench for ili9341_spi_rx.
// Drives the SPI pins bit by bit (sck at 1/4 of clk or slower) and collects
// pixel events into a queue that is compared against hand-computed values.
// Counter checks are compiled in when ILI_RX_STATS_EN is defined.
module tb_ili9341_spi_rx;
    import ili9341_pkg::*;

    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] rgb;
    } pix_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ili9341_spi_rx_if bus ();

    ili9341_spi_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_X       (240),
        .MAX_Y       (320)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pix_t       pix_q[$];
    int         byte_seen = 0;
    int         n_compared = 0;
    int         n_mismatched = 0;
    int         last_latency;
    logic [7:0] last_byte;
    logic       last_is_data;
    int         bytes_before;

    // Record every pulse on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.pix_valid) begin
            pix_q.push_back({bus.pix_x, bus.pix_y, bus.pix_rgb});
        end
        if (bus.byte_valid) begin
            byte_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Shift out the top nbits of value; on the 8th bit, measure how many
    // posedges elapse from sck rising until byte_valid appears.
    task automatic sendBits(input logic [7:0] value, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.spi_cs   = 1'b0;
            bus.spi_dc   = dc;
            bus.spi_mosi = value[7-i];
            @(negedge clk);
            bus.spi_sck = 1'b1;
            if (i == 7) begin
                last_latency = 99;
                for (int c = 1; c <= 8; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.byte_valid) begin
                        last_latency = c;
                        last_byte    = bus.byte_data;
                        last_is_data = bus.byte_is_data;
                        break;
                    end
                end
            end else begin
                @(negedge clk);
            end
            @(negedge clk);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value, input logic dc);
        sendBits(value, dc, 8);
    endtask

    task automatic csHigh();
        @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic checkPix(input string tag, input int idx, input logic [15:0] ex,
                            input logic [15:0] ey, input logic [15:0] ergb);
        if (idx < pix_q.size()) begin
            checkOutput({tag, "_x"},   32'(pix_q[idx].x),   32'(ex));
            checkOutput({tag, "_y"},   32'(pix_q[idx].y),   32'(ey));
            checkOutput({tag, "_rgb"}, 32'(pix_q[idx].rgb), 32'(ergb));
        end
    endtask

    task automatic checkOutputsZero(input string tag);
        checkOutput({tag, "_byte_valid"}, 32'(bus.byte_valid),   32'h0);
        checkOutput({tag, "_byte_data"},  32'(bus.byte_data),    32'h0);
        checkOutput({tag, "_is_data"},    32'(bus.byte_is_data), 32'h0);
        checkOutput({tag, "_cur_cmd"},    32'(bus.cur_cmd),      32'h0);
        checkOutput({tag, "_pix_valid"},  32'(bus.pix_valid),    32'h0);
        checkOutput({tag, "_pix_x"},      32'(bus.pix_x),        32'h0);
        checkOutput({tag, "_pix_y"},      32'(bus.pix_y),        32'h0);
        checkOutput({tag, "_pix_rgb"},    32'(bus.pix_rgb),      32'h0);
        checkOutput({tag, "_frame_err"},  32'(bus.frame_err),    32'h0);
`ifdef ILI_RX_STATS_EN
        checkOutput({tag, "_cmd_count"},  32'(bus.cmd_count),    32'h0);
        checkOutput({tag, "_pix_count"},  bus.pix_count,         32'h0);
`endif
    endtask

    logic [15:0] t2_x[7] = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11, 16'd12, 16'd10};
    logic [15:0] t2_y[7] = '{16'd5,  16'd5,  16'd5,  16'd6,  16'd6,  16'd6,  16'd5};

    initial begin
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_dc   = 1'b0;
        rst          = 1'b0;
        repeat (4) @(negedge clk);
        checkOutputsZero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single command byte: latency, byte outputs, cur_cmd.
        applyStimulus(8'h2A, 1'b0);
        checkOutput("t1_latency", 32'(last_latency), 32'(SYNC_STAGES + 1));
        checkOutput("t1_byte",    32'(last_byte),    32'h2A);
        checkOutput("t1_is_data", 32'(last_is_data), 32'h0);
        settle();
        checkOutput("t1_cur_cmd", 32'(bus.cur_cmd), 32'h2A);
        csHigh();

        // RAMWR on the reset window.
        pix_q.delete();
        applyStimulus(8'h2C, 1'b0);
        applyStimulus(8'h07, 1'b1);
        checkOutput("t3_is_data", 32'(last_is_data), 32'h1);
        applyStimulus(8'hE0, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h1F, 1'b1);
        csHigh();
        settle();
        checkOutput("t3_count", 32'(pix_q.size()), 32'd2);
        checkPix("t3_p0", 0, 16'd0, 16'd0, 16'h07E0);
        checkPix("t3_p1", 1, 16'd1, 16'd0, 16'h001F);
`ifdef ILI_RX_STATS_EN
        checkOutput("t3_cmd_count", 32'(bus.cmd_count), 32'd2);
        checkOutput("t3_pix_count", bus.pix_count,      32'd2);
`endif

        // Window 10..12 x 5..6, seven pixels split across two transactions.
        pix_q.delete();
        applyStimulus(8'h2A, 1'b0);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h0A, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h0C, 1'b1);
        applyStimulus(8'h2B, 1'b0);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h06, 1'b1);
        applyStimulus(8'h2C, 1'b0);
        for (int p = 0; p < 7; p++) begin
            applyStimulus(8'hF8, 1'b1);
            applyStimulus(8'h00, 1'b1);
            if (p == 2) begin
                csHigh();
            end
        end
        csHigh();
        settle();
        checkOutput("t2_count", 32'(pix_q.size()), 32'd7);
        for (int p = 0; p < 7; p++) begin
            checkPix($sformatf("t2_p%0d", p), p, t2_x[p], t2_y[p], 16'hF800);
        end

        // Inverted column window plus trailing CASET bytes that are ignored.
        pix_q.delete();
        applyStimulus(8'h2A, 1'b0);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h09, 1'b1);
        applyStimulus(8'h2B, 1'b0);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h2C, 1'b0);
        applyStimulus(8'h12, 1'b1); applyStimulus(8'h34, 1'b1);
        applyStimulus(8'h56, 1'b1); applyStimulus(8'h78, 1'b1);
        applyStimulus(8'h9A, 1'b1); applyStimulus(8'hBC, 1'b1);
        csHigh();
        settle();
        checkOutput("t7_count", 32'(pix_q.size()), 32'd3);
        checkPix("t7_p0", 0, 16'd5, 16'd1, 16'h1234);
        checkPix("t7_p1", 1, 16'd5, 16'd2, 16'h5678);
        checkPix("t7_p2", 2, 16'd5, 16'd1, 16'h9ABC);

        // cs raised after 5 bits: byte dropped, frame_err set then cleared.
        bytes_before = byte_seen;
        sendBits(8'hA5, 1'b0, 5);
        csHigh();
        settle();
        checkOutput("t4_no_byte",   32'(byte_seen - bytes_before), 32'd0);
        checkOutput("t4_frame_err", 32'(bus.frame_err), 32'h1);
        applyStimulus(8'h2C, 1'b0);
        settle();
        checkOutput("t4_err_clear", 32'(bus.frame_err), 32'h0);

        // Half pixel dropped by a command byte; new RAMWR restarts at (xs,ys).
        pix_q.delete();
        applyStimulus(8'hAB, 1'b1);
        applyStimulus(8'h00, 1'b0);
        settle();
        checkOutput("t5_no_pix",  32'(pix_q.size()), 32'd0);
        checkOutput("t5_cur_cmd", 32'(bus.cur_cmd),  32'h00);
        applyStimulus(8'h2C, 1'b0);
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        csHigh();
        settle();
        checkOutput("t5_count", 32'(pix_q.size()), 32'd1);
        checkPix("t5_p0", 0, 16'd5, 16'd1, 16'h1234);

        // Reset in the middle of a RAMWR pixel and a partial byte.
        applyStimulus(8'h2C, 1'b0);
        applyStimulus(8'h55, 1'b1);
        sendBits(8'hFF, 1'b1, 3);
        @(negedge clk);
        rst        = 1'b0;
        bus.spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        checkOutputsZero("t6_reset");
        bytes_before = byte_seen;
        pix_q.delete();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("t6_no_byte", 32'(byte_seen - bytes_before), 32'd0);
        checkOutput("t6_no_pix",  32'(pix_q.size()), 32'd0);

        // Reset window is 0..239 columns: pixel 239 at (239,0), 240 at (0,1).
        applyStimulus(8'h2C, 1'b0);
        for (int p = 0; p < 241; p++) begin
            applyStimulus(8'(p >> 8), 1'b1);
            applyStimulus(8'(p), 1'b1);
        end
        csHigh();
        settle();
        checkOutput("t6_count", 32'(pix_q.size()), 32'd241);
        checkPix("t6_p0",   0,   16'd0,   16'd0, 16'd0);
        checkPix("t6_p239", 239, 16'd239, 16'd0, 16'd239);
        checkPix("t6_p240", 240, 16'd0,   16'd1, 16'd240);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
